// File: rtl/axis_rr_arbiter_8_if.sv
// Handshake/control bundle between the 8-input AXI-Stream mux, its downstream sink and the round-robin arbiter.
interface axis_rr_arbiter_8_if;
    logic [7:0] req;
    logic [2:0] sel;
    logic       mux_valid;
    logic       mux_ready;
    logic       valid_out;
    logic       ready_in;
    logic       grant_active;

    modport master (
        input  req,
        input  mux_valid,
        input  ready_in,
        output sel,
        output mux_ready,
        output valid_out,
        output grant_active
    );

    modport slave (
        output req,
        output mux_valid,
        output ready_in,
        input  sel,
        input  mux_ready,
        input  valid_out,
        input  grant_active
    );
endinterface

// File: rtl/axis_rr_arbiter_8.sv
// Round-robin, burst-holding grant controller for an 8-input AXI-Stream mux.
// Define AXIS_ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST beats.
module axis_rr_arbiter_8 #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_rr_arbiter_8_if.master   arb
);
    localparam int unsigned NumSrc = 8;
    localparam int unsigned IdxW   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_max_burst_range
        $error("MAX_BURST must be within 1..255");
    end

    state_e            state_q, state_d;
    logic [IdxW-1:0]   sel_q, sel_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic              grant_active;
    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;

`ifdef AXIS_ARB_BURST_LIMIT_EN
    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);

    logic [CntW-1:0]   burst_cnt_q, burst_cnt_d;
    logic              beat;
`endif

    assign grant_active = (state_q == GRANT);

    // Gating is combinational so reset or release drops the handshake in the same instant.
    assign arb.grant_active = grant_active;
    assign arb.sel          = sel_q;
    assign arb.valid_out    = grant_active & arb.mux_valid;
    assign arb.mux_ready    = grant_active & arb.ready_in;

`ifdef AXIS_ARB_BURST_LIMIT_EN
    assign beat = grant_active & arb.mux_valid & arb.ready_in;
`endif

    // Search last+1 .. last+8 (mod 8); the final step wraps back onto last itself.
    always_comb begin : rr_search
        pick_found = 1'b0;
        pick_idx   = last_q;
        for (int unsigned i = 1; i <= NumSrc; i++) begin
            if (!pick_found && arb.req[IdxW'(last_q + IdxW'(i))]) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'(last_q + IdxW'(i));
            end
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
`ifdef AXIS_ARB_BURST_LIMIT_EN
        burst_cnt_d = burst_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    state_d = GRANT;
`ifdef AXIS_ARB_BURST_LIMIT_EN
                    burst_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
                if (!arb.mux_valid) begin
                    last_d  = sel_q;
                    state_d = IDLE;
                end
`ifdef AXIS_ARB_BURST_LIMIT_EN
                else if (beat) begin
                    if (burst_cnt_q == BurstLast) begin
                        last_d  = sel_q;
                        state_d = IDLE;
                    end else begin
                        burst_cnt_d = burst_cnt_q + CntW'(1);
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= IdxW'(NumSrc - 1);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

`ifdef AXIS_ARB_BURST_LIMIT_EN
    always_ff @(posedge clk or negedge rst_n) begin : burst_regs
        if (!rst_n) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter_8.sv
// Self-checking bench for axis_rr_arbiter_8: source model feeds the mux, scoreboard checks the granted source of every beat.
module tb_axis_rr_arbiter_8;
    localparam int unsigned TbMaxBurst = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    axis_rr_arbiter_8_if ifc ();

    // Mux model: merged valid is the selected source's valid.
    assign ifc.mux_valid = ifc.req[ifc.sel];

    axis_rr_arbiter_8 #(.MAX_BURST(TbMaxBurst)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (ifc)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cnt [8];
    logic [2:0]  exp_q [$];
    int unsigned idle_run;
    int unsigned beats_seen;
    bit          seen_grant;
    bit          prev_ga;
    logic [2:0]  prev_sel;

    task automatic drive_req();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = (cnt[i] != 0);
        ifc.req = r;
    endtask

    task automatic clear_track();
        idle_run   = 0;
        beats_seen = 0;
        seen_grant = 1'b0;
        prev_ga    = 1'b0;
        prev_sel   = '0;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < 8; i++) cnt[i] = 0;
        exp_q.delete();
    endtask

    // One cycle: sample at negedge (values that the next posedge will see), drive #1 after posedge.
    task automatic tick();
        logic [2:0] exp_sel;
        @(negedge clk);
        if (ifc.grant_active) begin
            if (prev_ga) begin
                checks++;
                if (ifc.sel !== prev_sel) begin
                    errors++;
                    $display("FAIL sel_stable: sel=%0d changed from %0d during grant", ifc.sel, prev_sel);
                end
            end else if (seen_grant) begin
                checks++;
                if (idle_run !== 1) begin
                    errors++;
                    $display("FAIL bubble: idle cycles=%0d expected 1", idle_run);
                end
            end
            seen_grant = 1'b1;
            idle_run   = 0;
        end else begin
            idle_run++;
        end
        prev_ga  = ifc.grant_active;
        prev_sel = ifc.sel;
        if (ifc.valid_out && ifc.ready_in) begin
            beats_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: beat from sel=%0d with empty scoreboard", ifc.sel);
            end else begin
                exp_sel = exp_q.pop_front();
                if (ifc.sel !== exp_sel) begin
                    errors++;
                    $display("FAIL beat_source: sel=%0d expected %0d", ifc.sel, exp_sel);
                end
            end
            if (cnt[ifc.sel] > 0) cnt[ifc.sel]--;
        end
        @(posedge clk);
        #1;
        drive_req();
    endtask

    task automatic drain(input int unsigned max_cycles, input string name);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || ifc.grant_active || ifc.req != 8'h00) && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats left after %0d cycles", name, exp_q.size(), n);
            clear_sources();
            drive_req();
        end
    endtask

    task automatic check_beats(input int unsigned want, input string name);
        checks++;
        if (beats_seen !== want) begin
            errors++;
            $display("FAIL %s_beats: got %0d expected %0d", name, beats_seen, want);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_sources();
        ifc.req      = 8'h00;
        ifc.ready_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_track();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_sources();
        ifc.req      = 8'h00;
        ifc.ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (ifc.grant_active !== 1'b0) begin errors++; $display("FAIL rst_grant_active: got %b expected 0", ifc.grant_active); end
        if (ifc.sel !== 3'd0)          begin errors++; $display("FAIL rst_sel: got %0d expected 0", ifc.sel); end
        if (ifc.valid_out !== 1'b0)    begin errors++; $display("FAIL rst_valid_out: got %b expected 0", ifc.valid_out); end
        if (ifc.mux_ready !== 1'b0)    begin errors++; $display("FAIL rst_mux_ready: got %b expected 0", ifc.mux_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_track();
        // Single source 4, three beats.
        cnt[4] = 3;
        repeat (3) exp_q.push_back(3'd4);
        drive_req();
        checks++;
        if (ifc.grant_active !== 1'b0) begin errors++; $display("FAIL single_pre_grant: grant_active=%b expected 0", ifc.grant_active); end
        tick();
        checks += 2;
        if (ifc.grant_active !== 1'b1) begin errors++; $display("FAIL single_grant: grant_active=%b expected 1", ifc.grant_active); end
        if (ifc.sel !== 3'd4)          begin errors++; $display("FAIL single_sel: sel=%0d expected 4", ifc.sel); end
        drain(40, "single");
        check_beats(3, "single");
        checks++;
        if (ifc.grant_active !== 1'b0) begin errors++; $display("FAIL single_release: grant_active=%b expected 0", ifc.grant_active); end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cnt[i] = 2;
            exp_q.push_back(3'(i));
            exp_q.push_back(3'(i));
        end
        drive_req();
        drain(200, "rotation");
        check_beats(16, "rotation");
        clear_track();
        // Second lap after releasing 7 must start again at 0.
        for (int i = 0; i < 8; i++) begin
            cnt[i] = 1;
            exp_q.push_back(3'(i));
        end
        drive_req();
        drain(200, "rotation_wrap");
        check_beats(8, "rotation_wrap");
    endtask

    task automatic test_skip_gaps();
        do_reset();
        cnt[2] = 1;
        exp_q.push_back(3'd2);
        drive_req();
        drain(40, "skip_prime");
        clear_track();
        cnt[0] = 1;
        cnt[2] = 1;
        exp_q.push_back(3'd0);
        exp_q.push_back(3'd2);
        drive_req();
        drain(60, "skip_gaps");
        check_beats(2, "skip_gaps");
    endtask

    task automatic test_backpressure();
        do_reset();
        ifc.ready_in = 1'b0;
        cnt[3] = 4;
        drive_req();
        tick();
        for (int k = 0; k < 5; k++) begin
            checks += 3;
            if (ifc.valid_out !== 1'b1) begin errors++; $display("FAIL stall_valid_out: got %b expected 1 (cycle %0d)", ifc.valid_out, k); end
            if (ifc.mux_ready !== 1'b0) begin errors++; $display("FAIL stall_mux_ready: got %b expected 0 (cycle %0d)", ifc.mux_ready, k); end
            if (ifc.sel !== 3'd3)       begin errors++; $display("FAIL stall_sel: got %0d expected 3 (cycle %0d)", ifc.sel, k); end
            tick();
        end
        check_beats(0, "stall");
        ifc.ready_in = 1'b1;
        repeat (4) exp_q.push_back(3'd3);
        drain(40, "stall_resume");
        check_beats(4, "stall_resume");
    endtask

    task automatic test_long_burst();
        do_reset();
        cnt[5] = 1;
        exp_q.push_back(3'd5);
        drive_req();
        drain(40, "long_prime");
        clear_track();
        cnt[6] = 20;
        cnt[1] = 2;
`ifdef AXIS_ARB_BURST_LIMIT_EN
        repeat (TbMaxBurst) exp_q.push_back(3'd6);
        repeat (2) exp_q.push_back(3'd1);
        repeat (20 - TbMaxBurst) exp_q.push_back(3'd6);
`else
        repeat (20) exp_q.push_back(3'd6);
        repeat (2) exp_q.push_back(3'd1);
`endif
        drive_req();
        drain(300, "long_burst");
        check_beats(22, "long_burst");
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        cnt[5] = 10;
        repeat (10) exp_q.push_back(3'd5);
        drive_req();
        repeat (3) tick();
        checks++;
        if (ifc.valid_out !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", ifc.valid_out); end
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (ifc.valid_out !== 1'b0)    begin errors++; $display("FAIL midrst_valid_out: got %b expected 0", ifc.valid_out); end
        if (ifc.mux_ready !== 1'b0)    begin errors++; $display("FAIL midrst_mux_ready: got %b expected 0", ifc.mux_ready); end
        if (ifc.grant_active !== 1'b0) begin errors++; $display("FAIL midrst_grant_active: got %b expected 0", ifc.grant_active); end
        clear_sources();
        drive_req();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_track();
        cnt[7] = 1;
        exp_q.push_back(3'd7);
        drive_req();
        tick();
        checks += 2;
        if (ifc.grant_active !== 1'b1) begin errors++; $display("FAIL midrst_regrant: grant_active=%b expected 1", ifc.grant_active); end
        if (ifc.sel !== 3'd7)          begin errors++; $display("FAIL midrst_sel: sel=%0d expected 7", ifc.sel); end
        drain(40, "midrst");
        check_beats(1, "midrst");
    endtask

    initial begin
        rst_n        = 1'b0;
        ifc.req      = 8'h00;
        ifc.ready_in = 1'b0;
        clear_track();
        test_reset();
        test_rotation();
        test_skip_gaps();
        test_backpressure();
        test_long_burst();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
